// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default width.
package timer_pkg;
    localparam int TIMER_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;
endpackage

// File: rtl/down_counter.sv
// One digit of the timer: loadable down-counter that wraps to reload_val when
// decremented from zero, exposing a zero flag used as the borrow to the next digit.
module down_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] reload_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (count == '0) begin
                count <= reload_val;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/countdown_timer.sv
// hrs:min:sec countdown timer with load/start/pause/clear commands; the FSM and
// command arbitration live here, the three digits are borrow-chained down_counters.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] count_max,
    input  logic [WIDTH-1:0] count_max_hrs,
    input  logic [WIDTH-1:0] load_sec,
    input  logic [WIDTH-1:0] load_min,
    input  logic [WIDTH-1:0] load_hrs,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [WIDTH-1:0] count_sec,
    output logic [WIDTH-1:0] count_min,
    output logic [WIDTH-1:0] count_hrs,
    output logic             busy,
    output logic             done
);

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] value,
                                               input logic [WIDTH-1:0] limit);
        return (value > limit) ? limit : value;
    endfunction

    timer_state_t state, state_next;

    logic             cnt_load;
    logic             load_zero;
    logic             tick;
    logic             sec_zero, min_zero, hrs_zero;
    logic             all_zero, last_tick;
    logic [WIDTH-1:0] sec_load_val, min_load_val, hrs_load_val;

    assign all_zero  = sec_zero && min_zero && hrs_zero;
    assign last_tick = (count_sec == WIDTH'(1)) && min_zero && hrs_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN) || (state_next == PAUSED);
            done  <= (state_next == DONE);
        end
    end

    // A load that is refused (RUN/DONE) does not mask start/pause/tick below it.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        load_zero  = 1'b0;
        tick       = 1'b0;
        if (clear) begin
            state_next = IDLE;
            cnt_load   = 1'b1;
            load_zero  = 1'b1;
        end else if (load && (state == IDLE || state == PAUSED)) begin
            cnt_load = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = all_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (all_zero) begin
                        state_next = DONE;
                    end else if (en) begin
                        tick = 1'b1;
                        if (last_tick) begin
                            state_next = DONE;
                        end
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign sec_load_val = load_zero ? '0 : clamp(load_sec, count_max);
    assign min_load_val = load_zero ? '0 : clamp(load_min, count_max);
    assign hrs_load_val = load_zero ? '0 : clamp(load_hrs, count_max_hrs);

    down_counter #(.WIDTH(WIDTH)) u_sec (
        .clk        (clk),
        .reset      (reset),
        .en         (tick),
        .load       (cnt_load),
        .load_val   (sec_load_val),
        .reload_val (count_max),
        .count      (count_sec),
        .zero       (sec_zero)
    );

    down_counter #(.WIDTH(WIDTH)) u_min (
        .clk        (clk),
        .reset      (reset),
        .en         (tick && sec_zero),
        .load       (cnt_load),
        .load_val   (min_load_val),
        .reload_val (count_max),
        .count      (count_min),
        .zero       (min_zero)
    );

    // Hours only borrow when the whole total is nonzero, so their reload is never used.
    down_counter #(.WIDTH(WIDTH)) u_hrs (
        .clk        (clk),
        .reset      (reset),
        .en         (tick && sec_zero && min_zero),
        .load       (cnt_load),
        .load_val   (hrs_load_val),
        .reload_val (count_max_hrs),
        .count      (count_hrs),
        .zero       (hrs_zero)
    );

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, hand-written corner sequences,
// and randomized commands checked against a total-seconds reference model.
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en, load, start, pause, clear;
    logic [W-1:0] count_max, count_max_hrs;
    logic [W-1:0] load_sec, load_min, load_hrs;
    logic [W-1:0] count_sec, count_min, count_hrs;
    logic         busy, done;

    int errors = 0;
    int checks = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .count_max     (count_max),
        .count_max_hrs (count_max_hrs),
        .load_sec      (load_sec),
        .load_min      (load_min),
        .load_hrs      (load_hrs),
        .load          (load),
        .start         (start),
        .pause         (pause),
        .clear         (clear),
        .count_sec     (count_sec),
        .count_min     (count_min),
        .count_hrs     (count_hrs),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         clr, ld, st, ps, tk;
        logic [W-1:0] ls, lm, lh;
        logic [W-1:0] es, em, eh;
        logic         eb, ed;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic clr, input logic ld, input logic st, input logic ps,
                                input logic tk, input int ls, input int lm, input int lh,
                                input int es, input int em, input int eh,
                                input logic eb, input logic ed);
        vec_t v;
        v.clr = clr; v.ld = ld; v.st = st; v.ps = ps; v.tk = tk;
        v.ls = W'(ls); v.lm = W'(lm); v.lh = W'(lh);
        v.es = W'(es); v.em = W'(em); v.eh = W'(eh);
        v.eb = eb; v.ed = ed;
        return v;
    endfunction

    function automatic logic [31:0] pack(input logic b, input logic d, input logic [W-1:0] h,
                                         input logic [W-1:0] m, input logic [W-1:0] s);
        return {6'd0, b, d, h, m, s};
    endfunction

    function automatic logic [31:0] observed();
        return pack(busy, done, count_hrs, count_min, count_sec);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h (busy,done,hrs,min,sec) expected %h", name, act, exp);
        end
    endtask

    task automatic quiet();
        en = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int s, input int m, input int h);
        quiet();
        load_sec = W'(s); load_min = W'(m); load_hrs = W'(h); load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    // Reference model: remaining time held as one integer of seconds in radix cm+1.
    int m_total;
    int m_mode;   // 0 idle, 1 running, 2 paused, 3 expired
    int base;

    function automatic int clampi(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_step(input int cm, input int cmh);
        base = cm + 1;
        if (clear) begin
            m_total = 0;
            m_mode  = 0;
        end else if (load && (m_mode == 0 || m_mode == 2)) begin
            m_total = (clampi(int'(load_hrs), cmh) * base + clampi(int'(load_min), cm)) * base
                      + clampi(int'(load_sec), cm);
        end else if (m_mode == 0) begin
            if (start) m_mode = (m_total == 0) ? 3 : 1;
        end else if (m_mode == 1) begin
            if (pause) m_mode = 2;
            else if (m_total == 0) m_mode = 3;
            else if (en) begin
                m_total = m_total - 1;
                if (m_total == 0) m_mode = 3;
            end
        end else if (m_mode == 2) begin
            if (start) m_mode = 1;
        end else begin
            m_mode = 0;
        end
    endtask

    function automatic logic [31:0] model_pack();
        int s, m, h;
        s = m_total % base;
        m = (m_total / base) % base;
        h = m_total / (base * base);
        return pack(m_mode == 1 || m_mode == 2, m_mode == 3, W'(h), W'(m), W'(s));
    endfunction

    task automatic rand_phase(input int cm, input int cmh, input int n, input string name);
        int r;
        count_max = W'(cm);
        count_max_hrs = W'(cmh);
        quiet();
        clear = 1'b1;
        m_total = 0;
        m_mode = 0;
        base = cm + 1;
        cyc();
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99); clear = (r < 2);
            r = $urandom_range(0, 99); load  = (r < 10);
            r = $urandom_range(0, 99); start = (r < 15);
            r = $urandom_range(0, 99); pause = (r < 6);
            r = $urandom_range(0, 99); en    = (r < 75);
            load_sec = W'($urandom_range(0, cm + 3));
            load_min = W'($urandom_range(0, cm + 3));
            load_hrs = W'($urandom_range(0, cmh + 2));
            model_step(cm, cmh);
            cyc();
            chk(name, observed(), model_pack());
        end
        quiet();
    endtask

    logic saw_done;

    initial begin
        reset = 1'b0;
        quiet();
        count_max = W'(59); count_max_hrs = W'(23);
        load_sec = '0; load_min = '0; load_hrs = '0;
        repeat (3) cyc();
        chk("reset_state", observed(), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        chk("after_release", observed(), 32'd0);

        // Directed vector table, one vector per clock.
        tbl[0]  = mk(0, 1, 0, 0, 0, 75, 0, 0,   59, 0, 0,   0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0,    0, 0, 0,    0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0,    0, 0, 0,    0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0,    0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 1,    0, 0, 1,    0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0,    0, 0, 1,    1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 0, 0, 0,    59, 59, 0,  1, 0);
        tbl[7]  = mk(0, 1, 0, 0, 1, 5, 5, 5,    58, 59, 0,  1, 0);
        tbl[8]  = mk(1, 1, 0, 0, 1, 5, 5, 5,    0, 0, 0,    0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0,    0, 0, 0,    0, 0);
        tbl[10] = mk(0, 1, 0, 0, 0, 30, 70, 30, 30, 59, 23, 0, 0);
        tbl[11] = mk(0, 0, 1, 1, 0, 0, 0, 0,    30, 59, 23, 1, 0);
        tbl[12] = mk(0, 0, 0, 1, 1, 0, 0, 0,    30, 59, 23, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 0,    30, 59, 23, 1, 0);
        tbl[14] = mk(0, 1, 0, 0, 0, 2, 0, 0,    2, 0, 0,    1, 0);
        tbl[15] = mk(0, 0, 1, 0, 0, 0, 0, 0,    2, 0, 0,    1, 0);
        tbl[16] = mk(0, 0, 0, 0, 1, 0, 0, 0,    1, 0, 0,    1, 0);
        tbl[17] = mk(0, 0, 0, 0, 1, 0, 0, 0,    0, 0, 0,    0, 1);
        tbl[18] = mk(0, 0, 0, 0, 1, 0, 0, 0,    0, 0, 0,    0, 0);
        tbl[19] = mk(0, 0, 1, 0, 0, 0, 0, 0,    0, 0, 0,    0, 1);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0,    0, 0);
        for (int i = 0; i < 21; i++) begin
            clear = tbl[i].clr; load = tbl[i].ld; start = tbl[i].st;
            pause = tbl[i].ps;  en = tbl[i].tk;
            load_sec = tbl[i].ls; load_min = tbl[i].lm; load_hrs = tbl[i].lh;
            cyc();
            chk($sformatf("vec%0d", i), observed(),
                pack(tbl[i].eb, tbl[i].ed, tbl[i].eh, tbl[i].em, tbl[i].es));
        end
        quiet();

        // 0:1:5 counted all the way down with en every cycle.
        do_load(5, 1, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        en = 1'b1;
        for (int t = 1; t <= 65; t++) begin
            cyc();
            if (t == 1)  chk("run65_t1",  observed(), pack(1, 0, 0, 1, 4));
            if (t == 6)  chk("run65_t6",  observed(), pack(1, 0, 0, 0, 59));
            if (t == 64) chk("run65_t64", observed(), pack(1, 0, 0, 0, 1));
            if (t == 65) chk("run65_done", observed(), pack(0, 1, 0, 0, 0));
        end
        cyc();
        chk("run65_idle", observed(), pack(0, 0, 0, 0, 0));
        quiet();

        // Pause freezes the count, start resumes it.
        do_load(3, 0, 0);
        start = 1'b1;
        cyc();
        start = 1'b0; en = 1'b1;
        cyc();
        chk("pz_tick1", observed(), pack(1, 0, 0, 0, 2));
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk("pz_paused", observed(), pack(1, 0, 0, 0, 2));
        repeat (5) cyc();
        chk("pz_frozen", observed(), pack(1, 0, 0, 0, 2));
        en = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0; en = 1'b1;
        chk("pz_resume", observed(), pack(1, 0, 0, 0, 2));
        cyc();
        chk("pz_tick2", observed(), pack(1, 0, 0, 0, 1));
        cyc();
        chk("pz_done", observed(), pack(0, 1, 0, 0, 0));
        en = 1'b0;
        cyc();
        chk("pz_idle", observed(), pack(0, 0, 0, 0, 0));

        rand_phase(4, 3, 1500, "rand_cm4");
        rand_phase(9, 2, 1500, "rand_cm9");

        // Asynchronous reset in the middle of a run: no expiry may follow.
        count_max = W'(59); count_max_hrs = W'(23);
        do_load(2, 0, 0);
        start = 1'b1;
        cyc();
        start = 1'b0; en = 1'b1;
        cyc();
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_now", observed(), 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (done || busy) saw_done = 1'b1;
        end
        chk("no_done_after_reset", {31'd0, saw_done}, 32'd0);
        chk("post_reset_state", observed(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
